// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store. LS has priority,
// IF gets an anti-starvation guarantee, and WAIT is bounded by a response timeout.
module mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TIMEOUT    = 255,
    parameter int MAX_LS_RUN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_wmask_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                err_o,
    output logic                busy_o
);
    localparam int MW = DATA_W / 8;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int RW = (MAX_LS_RUN < 1) ? 1 : $clog2(MAX_LS_RUN + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_LS_RUN);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e            state_q;
    logic              owner_ls_q;
    logic [RW-1:0]     ls_run_q;
    logic [TW-1:0]     tmo_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MW-1:0]     wmask_q;

    logic              ls_win_d;
    logic              in_req;
    logic              in_wait;
    logic              accept;
    logic              resp_ok;
    logic              tmo_hit;
    logic              resp;
    logic [DATA_W-1:0] resp_data;

    // IF is forced through once LS has won MAX_LS_RUN times in a row against a pending fetch.
    assign ls_win_d = ls_req_i && !(if_req_i && (ls_run_q == RUN_MAX));

    // Request payload registers carry no reset; outputs are masked by state instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_ls_q <= 1'b0;
            ls_run_q   <= '0;
            tmo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!if_req_i || !ls_win_d) begin
                        ls_run_q <= '0;
                    end else begin
                        ls_run_q <= ls_run_q + 1'b1;
                    end
                    if (if_req_i || ls_req_i) begin
                        owner_ls_q <= ls_win_d;
                        addr_q     <= ls_win_d ? ls_addr_i : if_addr_i;
                        we_q       <= ls_win_d && ls_we_i;
                        wdata_q    <= ls_win_d ? ls_wdata_i : '0;
                        wmask_q    <= ls_win_d ? ls_wmask_i : '0;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        tmo_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (mem_rvalid_i || (tmo_q == TMO_LAST)) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_req    = (state_q == S_REQ);
    assign in_wait   = (state_q == S_WAIT);
    assign accept    = in_req && mem_ready_i;
    assign resp_ok   = in_wait && mem_rvalid_i;
    assign tmo_hit   = in_wait && !mem_rvalid_i && (tmo_q == TMO_LAST);
    assign resp      = resp_ok || tmo_hit;
    assign resp_data = resp_ok ? mem_rdata_i : '0;

    assign if_gnt_o    = accept && !owner_ls_q;
    assign ls_gnt_o    = accept && owner_ls_q;
    assign if_rvalid_o = resp && !owner_ls_q;
    assign ls_rvalid_o = resp && owner_ls_q;
    assign if_rdata_o  = (resp && !owner_ls_q) ? resp_data : '0;
    assign ls_rdata_o  = (resp && owner_ls_q) ? resp_data : '0;
    assign err_o       = tmo_hit;

    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req && we_q;
    assign mem_addr_o  = in_req ? addr_q : '0;
    assign mem_wdata_o = in_req ? wdata_q : '0;
    assign mem_wmask_o = in_req ? wmask_q : '0;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, LS priority, starvation guard, timeout,
// backpressure and reset in flight, with hand-computed expectations.
module tb_mem_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic [7:0]        ls_wmask_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [7:0]        mem_wmask_o;
    logic              mem_ready_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              err_o;
    logic              busy_o;

    int passed = 0;
    int total  = 0;

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8), .MAX_LS_RUN(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [5:0]  exp_ls_pat;
        logic        exp_ls;
        logic [63:0] exp_addr;

        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_wmask_i = '0;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        tick();
        tick();
        settle();
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_mem_req", mem_req_o, 1'b0);
        chk64("rst_mem_addr", mem_addr_o, 64'h0);
        chk1("rst_gnt", if_gnt_o | ls_gnt_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk64("rst_if_rdata", if_rdata_o, 64'h0);
        rst = 1'b0;
        tick();

        // IF-only fetch
        if_req_i = 1'b1; if_addr_i = 64'h8000_0000; mem_ready_i = 1'b1;
        settle();
        chk1("if_idle_req", mem_req_o, 1'b0);
        tick();
        settle();
        chk1("if_req", mem_req_o, 1'b1);
        chk64("if_addr", mem_addr_o, 64'h8000_0000);
        chk1("if_we", mem_we_o, 1'b0);
        chk1("if_gnt", if_gnt_o, 1'b1);
        chk1("if_ls_gnt", ls_gnt_o, 1'b0);
        tick();
        if_req_i = 1'b0;
        settle();
        chk1("if_wait_req", mem_req_o, 1'b0);
        chk1("if_wait_rvalid", if_rvalid_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0010_0093;
        settle();
        chk1("if_rvalid", if_rvalid_o, 1'b1);
        chk64("if_rdata", if_rdata_o, 64'h0010_0093);
        chk1("if_ls_rvalid", ls_rvalid_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk1("if_done_busy", busy_o, 1'b0);
        chk64("if_done_rdata", if_rdata_o, 64'h0);

        // Simultaneous IF and LS: LS store first
        if_req_i = 1'b1; if_addr_i = 64'h8000_0004;
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 64'h8000_1000;
        ls_wdata_i = 64'hdead_beef; ls_wmask_i = 8'h0f;
        tick();
        settle();
        chk1("both_ls_gnt", ls_gnt_o, 1'b1);
        chk1("both_if_gnt", if_gnt_o, 1'b0);
        chk1("both_we", mem_we_o, 1'b1);
        chk8("both_mask", mem_wmask_o, 8'h0f);
        chk64("both_addr", mem_addr_o, 64'h8000_1000);
        chk64("both_wdata", mem_wdata_o, 64'hdead_beef);
        tick();
        ls_req_i = 1'b0; ls_we_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1234;
        settle();
        chk1("both_ls_ack", ls_rvalid_o, 1'b1);
        chk1("both_if_noack", if_rvalid_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        tick();
        settle();
        chk1("both_if_gnt2", if_gnt_o, 1'b1);
        chk64("both_if_addr2", mem_addr_o, 64'h8000_0004);
        chk1("both_if_we2", mem_we_o, 1'b0);
        chk8("both_if_mask2", mem_wmask_o, 8'h00);
        tick();
        if_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h5678;
        settle();
        chk64("both_if_rdata2", if_rdata_o, 64'h5678);
        tick();
        mem_rvalid_i = 1'b0;
        tick();

        // Starvation guard: expected order LS,LS,LS,LS,IF,LS (bit i = LS wins)
        exp_ls_pat = 6'b101111;
        if_req_i = 1'b1; if_addr_i = 64'h8000_0100;
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 64'h9000_0000;
        for (int i = 0; i < 6; i++) begin
            exp_ls   = exp_ls_pat[i];
            exp_addr = exp_ls ? 64'h9000_0000 : 64'h8000_0100;
            tick();
            settle();
            chk1("starve_ls_gnt", ls_gnt_o, exp_ls);
            chk1("starve_if_gnt", if_gnt_o, !exp_ls);
            chk64("starve_addr", mem_addr_o, exp_addr);
            tick();
            mem_rvalid_i = 1'b1; mem_rdata_i = 64'(i);
            tick();
            mem_rvalid_i = 1'b0;
        end
        if_req_i = 1'b0; ls_req_i = 1'b0;
        tick();

        // Timeout after 8 WAIT cycles
        if_req_i = 1'b1; if_addr_i = 64'h8000_0200; mem_rdata_i = 64'habc;
        tick();
        settle();
        chk1("tmo_gnt", if_gnt_o, 1'b1);
        tick();
        if_req_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            settle();
            chk1("tmo_early_err", err_o, 1'b0);
            chk1("tmo_early_rvalid", if_rvalid_o, 1'b0);
            tick();
        end
        settle();
        chk1("tmo_err", err_o, 1'b1);
        chk1("tmo_rvalid", if_rvalid_o, 1'b1);
        chk64("tmo_rdata", if_rdata_o, 64'h0);
        tick();
        settle();
        chk1("tmo_after_err", err_o, 1'b0);
        chk1("tmo_after_busy", busy_o, 1'b0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hffff;
        settle();
        chk1("tmo_stray_if", if_rvalid_o, 1'b0);
        chk1("tmo_stray_ls", ls_rvalid_o, 1'b0);
        chk64("tmo_stray_rdata", if_rdata_o, 64'h0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk1("tmo_stray_busy", busy_o, 1'b0);

        // Backpressure: ready low for 5 REQ cycles, grant on the 6th
        mem_ready_i = 1'b0;
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 64'h8000_2000;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) ls_addr_i = 64'h8000_3000;
            settle();
            chk1("bp_req", mem_req_o, 1'b1);
            chk64("bp_addr", mem_addr_o, 64'h8000_2000);
            chk1("bp_gnt", ls_gnt_o, 1'b0);
            tick();
        end
        mem_ready_i = 1'b1;
        settle();
        chk1("bp_req6", mem_req_o, 1'b1);
        chk64("bp_addr6", mem_addr_o, 64'h8000_2000);
        chk1("bp_gnt6", ls_gnt_o, 1'b1);
        tick();
        ls_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h55;
        settle();
        chk1("bp_rvalid", ls_rvalid_o, 1'b1);
        chk64("bp_rdata", ls_rdata_o, 64'h55);
        tick();
        mem_rvalid_i = 1'b0;
        tick();

        // Reset during WAIT
        if_req_i = 1'b1; if_addr_i = 64'h8000_0300;
        tick();
        tick();
        if_req_i = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        chk1("rstw_busy_before", busy_o, 1'b1);
        tick();
        rst = 1'b0;
        settle();
        chk1("rstw_busy", busy_o, 1'b0);
        chk1("rstw_mem_req", mem_req_o, 1'b0);
        chk64("rstw_mem_addr", mem_addr_o, 64'h0);
        chk1("rstw_rvalid", if_rvalid_o, 1'b0);
        chk1("rstw_err", err_o, 1'b0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h77;
        settle();
        chk1("rstw_late_rvalid", if_rvalid_o, 1'b0);
        chk64("rstw_late_rdata", if_rdata_o, 64'h0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk1("rstw_late_busy", busy_o, 1'b0);
        if_req_i = 1'b1; if_addr_i = 64'h8000_0400;
        tick();
        settle();
        chk1("rstw_new_gnt", if_gnt_o, 1'b1);
        chk64("rstw_new_addr", mem_addr_o, 64'h8000_0400);
        tick();
        if_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0000_0013;
        settle();
        chk1("rstw_new_rvalid", if_rvalid_o, 1'b1);
        chk64("rstw_new_rdata", if_rdata_o, 64'h0000_0013);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk1("rstw_new_busy", busy_o, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between instruction fetch (IF) and load/store (LS).
- Sits between the ifu/load-store path and the memory/DPI bridge, replacing the direct inst_i feed to the core.
- Runs one transaction at a time: arbitrate, then request, then wait for response, then return to idle.
- LS has priority, with an anti-starvation limit for IF and a response timeout.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; the byte mask is DATA_W/8 bits
- TIMEOUT, 255, cycles allowed in WAIT before the transaction is aborted with error (must be ≥1)
- MAX_LS_RUN, 4, consecutive LS grants allowed while IF is pending before IF is forced to win

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_req_i  in  1  fetch request; held high until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch accepted by memory (1-cycle pulse)
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  fetch data
- ls_req_i  in  1  load/store request; held high until ls_gnt_o
- ls_we_i  in  1  1 = store
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  DATA_W  store data
- ls_wmask_i  in  DATA_W/8  store byte mask
- ls_gnt_o  out  1  load/store accepted (1-cycle pulse)
- ls_rvalid_o  out  1  load data / store ack valid (1-cycle pulse)
- ls_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_wmask_o  out  DATA_W/8  memory byte mask
- mem_ready_i  in  1  memory accepts the request this cycle
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_W  memory response data
- err_o  out  1  timeout pulse
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values:
  - state = IDLE, owner = IF, LS run counter = 0, timeout counter = 0.
  - All mem_* outputs 0; all gnt/rvalid/err outputs 0; rdata outputs 0.
- States:
  - IDLE: if any request is present, latch winner, addr, we, wdata and wmask into registers; go to REQ. Otherwise stay.
  - REQ: mem_req_o = 1, driven from the latched registers. When mem_ready_i = 1: pulse the owner's gnt_o combinationally in that cycle, clear the timeout counter, go to WAIT.
  - WAIT: mem_req_o = 0; timeout counter increments each cycle.
    - If mem_rvalid_i = 1: owner's rvalid_o = 1 and rdata_o = mem_rdata_i (combinational pass-through); go to IDLE.
    - Else if counter = TIMEOUT-1: owner's rvalid_o = 1, rdata_o = 0, err_o = 1; go to IDLE.
- Arbitration in IDLE:
  - Only LS requesting → LS. Only IF requesting → IF.
  - Both requesting → LS, unless the LS run counter = MAX_LS_RUN, in which case IF wins.
  - LS run counter increments on each LS win while if_req_i = 1, and clears on any IF win or when if_req_i = 0.
- Timing:
  - Latency from request (in IDLE) to mem_req_o is 1 cycle.
  - Minimum transaction is 3 cycles: IDLE → REQ (accepted) → WAIT (rvalid).
  - There is one idle bubble before the next arbitration.
- Writes also wait for mem_rvalid_i as an acknowledgement; ls_rdata_o content is then don't-care.
- Non-owner gnt/rvalid outputs are always 0. rdata outputs are 0 whenever the matching rvalid is 0.
- mem_rvalid_i is ignored in IDLE and REQ (stray or late response after a timeout): no rvalid pulse, no state change.
- Requester inputs are sampled only in IDLE. Changes during REQ/WAIT do not alter the in-flight transaction.
- mem_ready_i held low indefinitely in REQ: stay in REQ (no timeout in REQ).
- Reset asserted in any state: next cycle is IDLE with reset values. The in-flight transaction is dropped and no rvalid is issued.
- All state is registered on the clk posedge. Only gnt/rvalid/rdata/err are combinational from state plus mem inputs.

Test Plan:
- IF-only fetch:
  - Stimulus: if_req_i = 1, addr = 0x80000000; mem_ready_i = 1 in the first REQ cycle; mem_rvalid_i = 1 with rdata = 0x00100093 two cycles later.
  - Required: mem_req_o high for exactly 1 cycle with addr 0x80000000 and we = 0; if_gnt_o pulses; if_rvalid_o pulses with 0x00100093; busy_o low afterwards.
- Simultaneous IF and LS requests (LS store to 0x80001000, wdata 0xdeadbeef, mask 0x0f):
  - Required: LS served first with mem_we_o = 1 and mask 0x0f; IF served in the next transaction.
- Starvation guard with MAX_LS_RUN = 4:
  - Stimulus: ls_req_i and if_req_i held high continuously.
  - Required: grant order LS, LS, LS, LS, IF, then LS again.
- Timeout with TIMEOUT = 8:
  - Stimulus: request accepted, mem_rvalid_i never asserted.
  - Required: after exactly 8 WAIT cycles, owner rvalid = 1 with rdata = 0 and err_o = 1. A later mem_rvalid_i pulse in IDLE produces no output.
- Backpressure:
  - Stimulus: mem_ready_i low for 5 cycles, then high.
  - Required: mem_req_o and mem_addr_o stay stable for all 6 REQ cycles; gnt pulses only on cycle 6.
- Reset mid-WAIT:
  - Stimulus: rst = 1 for 1 cycle.
  - Required: next cycle all outputs 0 and busy_o = 0. A mem_rvalid_i arriving afterwards is ignored. A new IF request completes normally.
